// File: rtl/timer_share_pkg.sv
// Shared types and register map for the timer share arbiter.
// Imported by the arbiter top and the testbench.
package timer_share_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STOP,
    LOAD,
    START,
    WAIT,
    RELEASE,
    DONE
  } state_e;

  typedef enum logic {
    RES_DONE,
    RES_ABORT
  } result_e;

  localparam int REG_CTRL_OFS    = 'h4;
  localparam int REG_CMP_OFS     = 'h8;
  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_PRESC_LSB  = 3;
  localparam int CTRL_PRESC_MSB  = 5;

  function automatic logic [31:0] ctrl_word(
    input logic [2:0] presc,
    input logic       en
  );
    logic [31:0] w;
    w = '0;
    w[CTRL_ENABLE_BIT] = en;
    w[CTRL_PRESC_MSB:CTRL_PRESC_LSB] = presc;
    return w;
  endfunction

endpackage

// File: rtl/timer_share_arbiter_rr.sv
// Combinational round-robin arbiter: the first request at or
// after ptr_i (wrapping) wins; grant is one-hot or zero.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  logic [PW:0]   sum;
  logic [PW-1:0] k;
  logic          found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    sum   = '0;
    k     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr_i} + (PW+1)'(i);
      if (sum >= (PW+1)'(NUM_REQ))
        sum = sum - (PW+1)'(NUM_REQ);
      k = PW'(sum);
      if (!found && req_i[k]) begin
        gnt_o[k] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_share_arbiter.sv
// Shares one APB timer between requesters needing one-shot delays:
// arbitrate, program the timer over APB, wait for compare match.
module timer_share_arbiter
  import timer_share_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMER_BASE     = 0
) (
  input  logic                           HCLK,
  input  logic                           HRESETn,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ-1:0][31:0]       delay_i,
  input  logic [NUM_REQ-1:0][2:0]        presc_i,
  output logic [NUM_REQ-1:0]             gnt_o,
  output logic [NUM_REQ-1:0]             done_o,
  output logic [NUM_REQ-1:0]             abort_o,
  output logic                           busy_o,
  output logic [APB_ADDR_WIDTH-1:0]      PADDR,
  output logic [31:0]                    PWDATA,
  output logic                           PWRITE,
  output logic                           PSEL,
  output logic                           PENABLE,
  input  logic [31:0]                    PRDATA,
  input  logic                           PREADY,
  input  logic                           PSLVERR,
  input  logic [1:0]                     irq_i
);

  localparam int PW = $clog2(NUM_REQ);
  localparam logic [APB_ADDR_WIDTH-1:0] CTRL_ADDR =
    APB_ADDR_WIDTH'(TIMER_BASE + REG_CTRL_OFS);
  localparam logic [APB_ADDR_WIDTH-1:0] CMP_ADDR =
    APB_ADDR_WIDTH'(TIMER_BASE + REG_CMP_OFS);

  state_e        state_q, state_d;
  result_e       res_q, res_d;
  logic          acc_q, acc_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx_q, idx_d;
  logic [31:0]   dly_q, dly_d;
  logic [2:0]    presc_q, presc_d;

  logic [NUM_REQ-1:0] win;
  logic [PW-1:0]      win_idx;
  logic               xfer;
  logic               xfer_done;
  logic               unused_ok;

  assign unused_ok = ^{PRDATA, irq_i[0]};

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_rr (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (win)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (win[i]) win_idx = PW'(i);
  end

  assign xfer = (state_q == STOP) || (state_q == LOAD) ||
                (state_q == START) || (state_q == RELEASE);
  assign xfer_done = xfer && acc_q && PREADY;

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    dly_d   = dly_q;
    presc_d = presc_q;
    acc_d   = xfer && (!acc_q || !PREADY);
    unique case (state_q)
      IDLE: if (|req_i) begin
        idx_d   = win_idx;
        dly_d   = delay_i[win_idx];
        presc_d = presc_i[win_idx];
        res_d   = RES_DONE;
        ptr_d   = (win_idx == PW'(NUM_REQ-1)) ?
                  '0 : win_idx + PW'(1);
        state_d = (delay_i[win_idx] == '0) ? DONE : STOP;
      end
      STOP, LOAD, START: if (xfer_done) begin
        if (PSLVERR) begin
          res_d   = RES_ABORT;
          state_d = RELEASE;
        end else begin
          state_d = (state_q == STOP) ? LOAD :
                    (state_q == LOAD) ? START : WAIT;
        end
      end
      // Compare match beats a simultaneous request drop.
      WAIT: if (irq_i[1]) begin
        res_d   = RES_DONE;
        state_d = RELEASE;
      end else if (!req_i[idx_q]) begin
        res_d   = RES_ABORT;
        state_d = RELEASE;
      end
      RELEASE: if (xfer_done) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      res_q   <= RES_DONE;
      acc_q   <= 1'b0;
      ptr_q   <= '0;
      idx_q   <= '0;
      dly_q   <= '0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      acc_q   <= acc_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      dly_q   <= dly_d;
      presc_q <= presc_d;
    end
  end

  always_comb begin
    PSEL    = xfer;
    PENABLE = xfer && acc_q;
    PWRITE  = xfer;
    PADDR   = '0;
    PWDATA  = '0;
    unique case (state_q)
      STOP:    PADDR = CTRL_ADDR;
      LOAD: begin
        PADDR  = CMP_ADDR;
        PWDATA = dly_q;
      end
      START: begin
        PADDR  = CTRL_ADDR;
        PWDATA = ctrl_word(presc_q, 1'b1);
      end
      RELEASE: PADDR = CTRL_ADDR;
      default: ;
    endcase
  end

  always_comb begin
    gnt_o   = '0;
    done_o  = '0;
    abort_o = '0;
    if (state_q != IDLE) gnt_o[idx_q] = 1'b1;
    if (state_q == DONE) begin
      if (res_q == RES_ABORT) abort_o[idx_q] = 1'b1;
      else                    done_o[idx_q]  = 1'b1;
    end
  end

  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_timer_share_arbiter.sv
// Randomized and directed bench for timer_share_arbiter with a
// behavioural APB timer and a transaction-level schedule model.
module tb_timer_share_arbiter;

  localparam int NR   = 4;
  localparam int AW   = 12;
  localparam int BASE = 'h100;
  localparam logic [AW-1:0] A_CTRL = AW'(BASE + 4);
  localparam logic [AW-1:0] A_CMP  = AW'(BASE + 8);
  localparam int K_GNT   = 0;
  localparam int K_DONE  = 1;
  localparam int K_ABORT = 2;

  typedef struct {
    int cyc;
    int idx;
    int kind;
  } ev_t;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  logic [NR-1:0] req = '0;
  logic [NR-1:0][31:0] delay_v = '0;
  logic [NR-1:0][2:0] presc_v = '0;
  logic [NR-1:0] gnt_o, done_o, abort_o;
  logic busy_o;
  logic [AW-1:0] PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic PWRITE, PSEL, PENABLE, PREADY, PSLVERR;
  logic [1:0] irq;
  logic f_irq0 = 1'b0, f_irq1 = 1'b0;
  logic stall_en = 1'b0, err_start = 1'b0;
  int acc_n = 0;
  logic t_en;
  logic [31:0] t_cmp, t_cnt;

  ev_t ev_q[$];
  ev_t exp_ev[$];
  logic [43:0] wlog[$];
  logic [43:0] exp_wr[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int model_ptr = 0;
  int psel_cnt = 0;
  int rem[NR];
  int cn[NR], dl[NR], pv[NR];
  int c, tot;
  logic [NR-1:0] gnt_prev = '0;
  logic [AW-1:0] su_addr = '0;
  logic [31:0] su_data = '0;

  always #5 HCLK = ~HCLK;

  timer_share_arbiter #(
    .NUM_REQ        (NR),
    .APB_ADDR_WIDTH (AW),
    .TIMER_BASE     (BASE)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .req_i   (req),
    .delay_i (delay_v),
    .presc_i (presc_v),
    .gnt_o   (gnt_o),
    .done_o  (done_o),
    .abort_o (abort_o),
    .busy_o  (busy_o),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PWRITE  (PWRITE),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .irq_i   (irq)
  );

  assign PRDATA = '0;
  assign PREADY = !(stall_en && PSEL && PENABLE &&
                    PADDR == A_CMP && acc_n < 3);
  assign PSLVERR = err_start && PSEL && PENABLE &&
                   PADDR == A_CTRL && PWDATA[0];
  assign irq = {(t_en && t_cnt >= t_cmp) || f_irq1, f_irq0};

  always @(posedge HCLK)
    acc_n <= (PSEL && PENABLE && !PREADY) ? acc_n + 1 : 0;

  always @(posedge HCLK)
    if (HRESETn && PSEL && PENABLE && PREADY)
      wlog.push_back({PADDR, PWDATA});

  // Timer: CMP write clears count; counts while enabled up to CMP.
  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      t_en  <= 1'b0;
      t_cmp <= '0;
      t_cnt <= '0;
    end else begin
      if (PSEL && PENABLE && PREADY && !PSLVERR &&
          PADDR == A_CTRL)
        t_en <= PWDATA[0];
      if (PSEL && PENABLE && PREADY && !PSLVERR &&
          PADDR == A_CMP) begin
        t_cmp <= PWDATA;
        t_cnt <= '0;
      end else if (t_en && t_cnt < t_cmp) begin
        t_cnt <= t_cnt + 1;
      end
    end
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_ev(input int cy, input int ix,
                         input int kd);
    exp_ev.push_back('{cyc: cy, idx: ix, kind: kd});
  endtask

  task automatic push_wr4(input int d, input int p);
    exp_wr.push_back({A_CTRL, 32'h0});
    exp_wr.push_back({A_CMP, 32'(d)});
    exp_wr.push_back({A_CTRL, 32'(p * 8 + 1)});
    exp_wr.push_back({A_CTRL, 32'h0});
  endtask

  task automatic tick();
    @(negedge HCLK);
    cyc++;
    check("gnt_onehot", 64'($onehot0(gnt_o)), 1);
    check("pwrite", PWRITE, PSEL);
    if (!PSEL)
      check("apb_idle", {PENABLE, PADDR, PWDATA}, 0);
    if (PSEL && !PENABLE) begin
      su_addr = PADDR;
      su_data = PWDATA;
    end
    if (PSEL && PENABLE) begin
      check("apb_addr_stable", PADDR, su_addr);
      check("apb_data_stable", PWDATA, su_data);
    end
    if (PSEL) psel_cnt++;
    for (int i = 0; i < NR; i++) begin
      if (gnt_o[i] && !gnt_prev[i])
        ev_q.push_back('{cyc: cyc, idx: i, kind: K_GNT});
      if (done_o[i])
        ev_q.push_back('{cyc: cyc, idx: i, kind: K_DONE});
      if (abort_o[i])
        ev_q.push_back('{cyc: cyc, idx: i, kind: K_ABORT});
      if ((done_o[i] || abort_o[i]) && rem[i] > 0) begin
        rem[i]--;
        if (rem[i] == 0) req[i] = 1'b0;
      end
    end
    gnt_prev = gnt_o;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (busy_o && n < 200);
    check("idle_timeout", 64'(n < 200), 1);
  endtask

  task automatic compare_logs(input string tag);
    ev_t e, x;
    logic [43:0] w, y;
    check({tag, "_nev"}, ev_q.size(), exp_ev.size());
    while (ev_q.size() > 0 && exp_ev.size() > 0) begin
      e = ev_q.pop_front();
      x = exp_ev.pop_front();
      check({tag, "_kind"}, e.kind, x.kind);
      check({tag, "_idx"}, e.idx, x.idx);
      check({tag, "_cyc"}, e.cyc, x.cyc);
    end
    check({tag, "_nwr"}, wlog.size(), exp_wr.size());
    while (wlog.size() > 0 && exp_wr.size() > 0) begin
      w = wlog.pop_front();
      y = exp_wr.pop_front();
      check({tag, "_wr"}, w, y);
    end
    ev_q.delete();
    exp_ev.delete();
    wlog.delete();
    exp_wr.delete();
  endtask

  // Schedule model: each requester re-requests until served cnt
  // times; idle PREADY, timer fires D cycles after it is started.
  task automatic run_batch(input int cnt[NR], input int dly[NR],
                           input int pr[NR], input string tag);
    int a, w, j, budget, left_tot;
    int left[NR];
    wait_idle();
    for (int i = 0; i < NR; i++) begin
      delay_v[i] = 32'(dly[i]);
      presc_v[i] = 3'(pr[i]);
      rem[i] = cnt[i];
      req[i] = (cnt[i] > 0);
      left[i] = cnt[i];
    end
    a = cyc;
    forever begin
      w = -1;
      for (int k = 0; k < NR; k++) begin
        j = (model_ptr + k) % NR;
        if (w < 0 && left[j] > 0) w = j;
      end
      if (w < 0) break;
      left[w]--;
      model_ptr = (w + 1) % NR;
      push_ev(a + 1, w, K_GNT);
      if (dly[w] == 0) begin
        push_ev(a + 1, w, K_DONE);
        a = a + 2;
      end else begin
        push_wr4(dly[w], pr[w]);
        push_ev(a + 10 + dly[w], w, K_DONE);
        a = a + 11 + dly[w];
      end
    end
    budget = 0;
    left_tot = 1;
    while (left_tot > 0 && budget < 3000) begin
      tick();
      budget++;
      left_tot = 0;
      for (int i = 0; i < NR; i++) left_tot += rem[i];
    end
    check({tag, "_timeout"}, 64'(budget < 3000), 1);
    compare_logs(tag);
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    req = '0;
    for (int i = 0; i < NR; i++) rem[i] = 0;
    repeat (2) tick();
    HRESETn = 1'b1;
    tick();
    model_ptr = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, gnt_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_abort"}, abort_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_apb"},
          {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 0);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) rem[i] = 0;
    tick();
    tick();
    check_all_zero("rst");
    HRESETn = 1'b1;
    tick();

    cn = '{1, 0, 0, 0};
    dl = '{5, 0, 0, 0};
    pv = '{0, 0, 0, 0};
    run_batch(cn, dl, pv, "single");

    do_reset();
    cn = '{1, 1, 1, 1};
    dl = '{3, 3, 3, 3};
    pv = '{0, 1, 2, 3};
    run_batch(cn, dl, pv, "rr4");
    cn = '{2, 1, 1, 1};
    run_batch(cn, dl, pv, "rr_hold");

    cn = '{0, 0, 1, 0};
    dl = '{0, 0, 0, 0};
    pv = '{0, 0, 6, 0};
    wait_idle();
    psel_cnt = 0;
    run_batch(cn, dl, pv, "zero");
    check("zero_psel", psel_cnt, 0);

    wait_idle();
    delay_v[1] = 1000;
    presc_v[1] = 0;
    req[1] = 1'b1;
    rem[1] = 1;
    c = cyc;
    push_ev(c + 1, 1, K_GNT);
    push_wr4(1000, 0);
    push_ev(c + 23, 1, K_ABORT);
    while (cyc < c + 20) tick();
    req[1] = 1'b0;
    repeat (6) tick();
    compare_logs("drop");
    model_ptr = 2;

    wait_idle();
    stall_en = 1'b1;
    delay_v[0] = 5;
    presc_v[0] = 0;
    req[0] = 1'b1;
    rem[0] = 1;
    c = cyc;
    push_ev(c + 1, 0, K_GNT);
    push_wr4(5, 0);
    push_ev(c + 18, 0, K_DONE);
    while (cyc < c + 21) tick();
    stall_en = 1'b0;
    compare_logs("stall");
    model_ptr = 1;

    wait_idle();
    err_start = 1'b1;
    delay_v[3] = 7;
    presc_v[3] = 5;
    req[3] = 1'b1;
    rem[3] = 1;
    c = cyc;
    push_ev(c + 1, 3, K_GNT);
    push_wr4(7, 5);
    push_ev(c + 9, 3, K_ABORT);
    while (cyc < c + 12) tick();
    err_start = 1'b0;
    compare_logs("slverr");
    model_ptr = 0;

    wait_idle();
    delay_v[1] = 32'hFFFF_FFFF;
    presc_v[1] = 0;
    req[1] = 1'b1;
    rem[1] = 1;
    c = cyc;
    push_ev(c + 1, 1, K_GNT);
    push_wr4(32'hFFFF_FFFF, 0);
    push_ev(c + 15, 1, K_DONE);
    while (cyc < c + 9) tick();
    f_irq0 = 1'b1;
    tick();
    f_irq0 = 1'b0;
    while (cyc < c + 12) tick();
    f_irq0 = 1'b1;
    f_irq1 = 1'b1;
    req[1] = 1'b0;
    tick();
    f_irq0 = 1'b0;
    f_irq1 = 1'b0;
    repeat (5) tick();
    compare_logs("irq_both");
    model_ptr = 2;

    wait_idle();
    delay_v[2] = 50;
    presc_v[2] = 0;
    req[2] = 1'b1;
    rem[2] = 1;
    c = cyc;
    push_ev(c + 1, 2, K_GNT);
    exp_wr.push_back({A_CTRL, 32'h0});
    exp_wr.push_back({A_CMP, 32'd50});
    exp_wr.push_back({A_CTRL, 32'h1});
    while (cyc < c + 10) tick();
    check("wait_busy", busy_o, 1);
    HRESETn = 1'b0;
    #1;
    check_all_zero("async_rst");
    req = '0;
    for (int i = 0; i < NR; i++) rem[i] = 0;
    repeat (2) tick();
    HRESETn = 1'b1;
    repeat (3) tick();
    check("post_rst_busy", busy_o, 0);
    compare_logs("rst_wait");
    model_ptr = 0;

    cn = '{1, 0, 1, 0};
    dl = '{2, 0, 4, 0};
    pv = '{1, 0, 2, 0};
    run_batch(cn, dl, pv, "post_rst");

    for (int r = 0; r < 24; r++) begin
      tot = 0;
      for (int i = 0; i < NR; i++) begin
        cn[i] = $urandom_range(0, 2);
        dl[i] = ($urandom_range(0, 3) == 0) ?
                0 : $urandom_range(1, 12);
        pv[i] = $urandom_range(0, 7);
        tot += cn[i];
      end
      if (tot == 0) cn[$urandom_range(0, NR - 1)] = 1;
      run_batch(cn, dl, pv, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_share_arbiter.md
Name: timer_share_arbiter

Overview:
- Shares one APB timer instance between NUM_REQ hardware requesters, each needing a one-shot delay.
- Round-robin arbitrates requests, then acts as the timer's sole APB master: stop, load compare, start with prescaler.
- Waits for the timer's compare-match interrupt, stops the timer and signals completion to the granted requester.
- Sits between requester logic and the timer's APB slave port and irq outputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- APB_ADDR_WIDTH, 12, APB address width
- TIMER_BASE, 0, APB base address of the timer; register offsets are added to it

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  reset, asynchronous, active-low
- req_i  in  NUM_REQ  per-requester request level; held until done_o or deliberately dropped to abort
- delay_i  in  NUM_REQ x 32  compare value (timer ticks) per requester; sampled at grant
- presc_i  in  NUM_REQ x 3  prescaler field per requester; sampled at grant
- gnt_o  out  NUM_REQ  one-hot grant
- done_o  out  NUM_REQ  one-cycle completion pulse
- abort_o  out  NUM_REQ  one-cycle pulse on abort or APB error
- busy_o  out  1  high whenever state != IDLE
- PADDR  out  APB_ADDR_WIDTH  APB master address
- PWDATA  out  32  APB write data
- PWRITE  out  1  always 1 during a transfer
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PRDATA  in  32  unused
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error
- irq_i  in  2  timer irq: [0] overflow (ignored), [1] compare match

Behaviour:
- Reset: all outputs 0; state IDLE; RR pointer 0, so requester 0 has highest priority; captured registers 0.
- Registers written (offsets): CTRL 0x4 (bit0 enable, bits5:3 prescaler), CMP 0x8. Writing CMP also clears the timer count.
- IDLE:
  - If any req_i, pick the winner round-robin starting at pointer. Capture index, delay and presc. gnt_o goes high next cycle.
  - Pointer becomes winner+1 mod NUM_REQ.
  - Winner delay == 0 -> DONE directly, no APB traffic.
  - Otherwise -> STOP.
- APB write states (STOP, LOAD, START, RELEASE):
  - Setup cycle: PSEL=1, PENABLE=0.
  - Access cycle(s): PSEL=1, PENABLE=1, held until PREADY.
  - PADDR/PWDATA stable for the whole transfer; next state on PREADY.
  - All APB outputs 0 outside transfers.
- STOP: CTRL <= 0.
- LOAD: CMP <= delay.
- START: CTRL <= {presc at bits5:3, enable=1}.
- WAIT:
  - irq_i[1] -> RELEASE with result=done.
  - Else req_i[gnt] low -> RELEASE with result=abort.
  - Both in the same cycle: done wins.
  - irq_i[0] ignored.
- RELEASE: CTRL <= 0, then -> DONE.
- DONE: one cycle.
  - done_o[gnt] or abort_o[gnt] = 1 per result.
  - gnt_o deasserts at the end of the cycle; -> IDLE.
- PSLVERR=1 on any access completion: abandon the sequence and go to RELEASE with result=abort. A PSLVERR during RELEASE itself goes straight to DONE.
- req_i dropped before WAIT: ignored; the sequence continues and completes as abort at WAIT entry.
- Requester still asserting req_i after DONE is re-arbitrated; round-robin gives other pending requesters precedence.
- Latency with PREADY=1, presc=0, delay D>0, arbitration cycle = t0:
  - STOP t1-t2, LOAD t3-t4, START t5-t6.
  - Timer counts from t7; irq_i[1] at t7+D.
  - RELEASE t8+D..t9+D; done_o at t10+D.
- Reset mid-sequence: immediate return to IDLE with all outputs 0. No APB cleanup; the timer is reset by the same HRESETn.

Decomposition:
- timer_share_pkg holds:
  - state enum {IDLE, STOP, LOAD, START, WAIT, RELEASE, DONE}
  - register offsets REG_CTRL_OFS=0x4, REG_CMP_OFS=0x8
  - CTRL_ENABLE_BIT=0, CTRL_PRESC_LSB=3, CTRL_PRESC_MSB=5
  - result enum {RES_DONE, RES_ABORT}
- One sub-module: rr_arbiter (NUM_REQ-wide, pointer in, one-hot grant out, combinational), reusable elsewhere.

Test Plan:
- req_i=0001, delay 5, presc 0, PREADY=1, real timer attached:
  - APB writes CTRL=0, CMP=5, CTRL=0x1, CTRL=0 in order.
  - done_o[0] at t0+15; abort_o stays 0.
- req_i=1111 all delay 3 from reset -> grants in order 0,1,2,3, each done_o exactly once. Then with req_i[0] held high: next grant goes to 0 only after 1,2,3 were served.
- req_i[2] with delay 0 -> gnt_o[2] then done_o[2] in the next cycle; PSEL never asserted.
- req_i[1], delay 1000; drop req_i[1] at t0+20 -> CTRL=0 written, abort_o[1] pulse, no done_o[1].
- PREADY held low 3 cycles on the CMP write -> PSEL/PENABLE/PADDR/PWDATA stable throughout, done delayed by 3 cycles. PSLVERR=1 on START -> RELEASE write, abort_o pulse.
- delay 0xFFFF_FFFF, irq_i[0] and irq_i[1] forced together -> done_o (not abort). HRESETn asserted during WAIT -> all outputs 0 asynchronously, IDLE afterwards.
